hazard_ctrl: RTL and testbench

- Parametrised scoreboard-based hazard unit for the in-order RISC-V pipeline.
- Generalises fixed one-cycle load-use detection: every destination-writing instruction issued from ID registers a result latency in a per-register countdown scoreboard; later consumers stall until the producer result is forwardable.
- Branch-taken flush is stretched over a configurable number of cycles.
- Drives PC enable, IF/ID enable, control inhibit (bubble insertion) and flush.

---
 rtl/hazard_ctrl.sv | 163 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: scoreboard-based data-hazard and branch-flush control for the
// in-order pipeline. Each destination-writing instruction issued from ID loads
// a per-register countdown with its result latency. Consumers stall until the
// count of every source they read has drained to zero. A taken branch holds
// flush for FLUSH_CYCLES cycles.
//
// Optional build macro HAZARD_PERF_CNT_EN adds saturating 32-bit stall and
// branch-flush event counters (stall_cnt_o, flush_cnt_o).
module hazard_ctrl #(
    parameter int unsigned NUM_REGS     = 32,
    parameter int unsigned REG_AW       = 5,
    parameter int unsigned LAT_W        = 3,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_rs1_used_i,
    input  logic              id_rs2_used_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_rd_wr_i,
    input  logic [LAT_W-1:0]  id_lat_i,
    input  logic              branch_taken_i,
    output logic              pc_en_o,
    output logic              if_en_o,
    output logic              inhibit_ctrl_o,
    output logic              flush_o,
    output logic              stall_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       flush_cnt_o
`endif
);

    // Full address space so any REG_AW-bit address indexes the busy vector;
    // entries at or above NUM_REGS are tied low and never flag a hazard.
    localparam int unsigned ADDR_SPACE = 2 ** REG_AW;
    // The flush counter only has to hold FLUSH_CYCLES-1.
    localparam int unsigned FCNT_W     = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FCNT_W-1:0] FCNT_LOAD = FCNT_W'(FLUSH_CYCLES - 1);

    logic [LAT_W-1:0]      cnt     [NUM_REGS];
    logic [LAT_W-1:0]      cnt_nxt [NUM_REGS];
    logic [ADDR_SPACE-1:0] busy;
    logic [FCNT_W-1:0]     fcnt;
    logic [FCNT_W-1:0]     fcnt_nxt;

    logic flush_active;
    logic rs1_hit;
    logic rs2_hit;
    logic hazard;
    logic issue;
    logic rd_load;

    // Busy flag per architectural register; x0 and out-of-range addresses stay clear.
    always_comb begin
        busy = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            busy[r] = (cnt[r] != '0);
        end
    end

    // Hazard detection and the issue qualifier that gates scoreboard writes.
    always_comb begin
        flush_active = (fcnt != '0);
        rs1_hit      = id_rs1_used_i && (id_rs1_i != '0) && busy[id_rs1_i];
        rs2_hit      = id_rs2_used_i && (id_rs2_i != '0) && busy[id_rs2_i];
        hazard       = id_valid_i && (rs1_hit || rs2_hit);
        issue        = id_valid_i && !hazard && !branch_taken_i && !flush_active;
        rd_load      = issue && id_rd_wr_i && (id_rd_i != '0);
    end

    // Scoreboard next state: a new producer's latency wins over the decrement.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_nxt[r] = cnt[r];
        end
        cnt_nxt[0] = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (rd_load && (id_rd_i == REG_AW'(r))) begin
                cnt_nxt[r] = id_lat_i;
            end else if (cnt[r] != '0) begin
                cnt_nxt[r] = cnt[r] - LAT_W'(1);
            end
        end
    end

    // Scoreboard counters; register 0 is reset and never loaded, so it stays zero.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= cnt_nxt[r];
            end
        end
    end

    // Flush stretch: every taken branch (re)loads the remaining flush cycles.
    always_comb begin
        fcnt_nxt = fcnt;
        if (branch_taken_i) begin
            fcnt_nxt = FCNT_LOAD;
        end else if (fcnt != '0) begin
            fcnt_nxt = fcnt - FCNT_W'(1);
        end
    end

    // Flush counter register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fcnt <= '0;
        end else begin
            fcnt <= fcnt_nxt;
        end
    end

    // Pipeline control in priority order: branch, flush tail, hazard, run.
    // Reset forces the free-running pattern regardless of inputs.
    always_comb begin
        pc_en_o        = 1'b1;
        if_en_o        = 1'b1;
        inhibit_ctrl_o = 1'b0;
        flush_o        = 1'b0;
        stall_o        = 1'b0;
        if (rst_n_i) begin
            if (branch_taken_i) begin
                if_en_o = 1'b0;
                flush_o = 1'b1;
            end else if (flush_active) begin
                flush_o = 1'b1;
            end else if (hazard) begin
                pc_en_o        = 1'b0;
                if_en_o        = 1'b0;
                inhibit_ctrl_o = 1'b1;
                stall_o        = 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Saturating event counters for stall cycles and taken branches.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (stall_o && (stall_cnt_o != 32'hFFFF_FFFF)) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
            if (branch_taken_i && (flush_cnt_o != 32'hFFFF_FFFF)) begin
                flush_cnt_o <= flush_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (FLUSH_CYCLES=3). Inputs change on the
// falling edge; outputs are sampled 2 time units later, well before the next
// rising edge. Expected outputs are queued with each stimulus step and popped
// for comparison.
module tb_hazard_ctrl;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned LAT_W  = 3;

    // {pc_en, if_en, inhibit_ctrl, flush, stall}
    localparam logic [4:0] RUN = 5'b11000;
    localparam logic [4:0] STL = 5'b00101;
    localparam logic [4:0] BRK = 5'b10010;
    localparam logic [4:0] FLS = 5'b11010;

    logic              clk_i = 1'b0;
    logic              rst_n_i;
    logic              id_valid_i;
    logic [REG_AW-1:0] id_rs1_i;
    logic [REG_AW-1:0] id_rs2_i;
    logic              id_rs1_used_i;
    logic              id_rs2_used_i;
    logic [REG_AW-1:0] id_rd_i;
    logic              id_rd_wr_i;
    logic [LAT_W-1:0]  id_lat_i;
    logic              branch_taken_i;
    logic              pc_en_o;
    logic              if_en_o;
    logic              inhibit_ctrl_o;
    logic              flush_o;
    logic              stall_o;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]       stall_cnt_o;
    logic [31:0]       flush_cnt_o;
`endif

    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       wr;
        logic [2:0] lat;
        logic       br;
        logic [4:0] exp;
    } step_t;

    logic [4:0] exp_q[$];
    step_t      steps[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         exp_stalls   = 0;
    int         exp_branches = 0;

    hazard_ctrl #(
        .NUM_REGS    (32),
        .REG_AW      (REG_AW),
        .LAT_W       (LAT_W),
        .FLUSH_CYCLES(3)
    ) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .id_valid_i    (id_valid_i),
        .id_rs1_i      (id_rs1_i),
        .id_rs2_i      (id_rs2_i),
        .id_rs1_used_i (id_rs1_used_i),
        .id_rs2_used_i (id_rs2_used_i),
        .id_rd_i       (id_rd_i),
        .id_rd_wr_i    (id_rd_wr_i),
        .id_lat_i      (id_lat_i),
        .branch_taken_i(branch_taken_i),
        .pc_en_o       (pc_en_o),
        .if_en_o       (if_en_o),
        .inhibit_ctrl_o(inhibit_ctrl_o),
        .flush_o       (flush_o),
        .stall_o       (stall_o)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt_o   (stall_cnt_o),
        .flush_cnt_o   (flush_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    function automatic step_t mk(logic v, logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                                 logic [4:0] rd, logic wr, logic [2:0] lat, logic br, logic [4:0] e);
        step_t s;
        s.v = v; s.rs1 = rs1; s.u1 = u1; s.rs2 = rs2; s.u2 = u2;
        s.rd = rd; s.wr = wr; s.lat = lat; s.br = br; s.exp = e;
        return s;
    endfunction

    function automatic step_t prod(logic [4:0] rd, logic [2:0] lat, logic [4:0] e);
        return mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, rd, 1'b1, lat, 1'b0, e);
    endfunction

    function automatic step_t cons1(logic [4:0] rs, logic [4:0] e);
        return mk(1'b1, rs, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0, 1'b0, e);
    endfunction

    function automatic step_t cons2(logic [4:0] rs, logic [4:0] e);
        return mk(1'b1, 5'd0, 1'b0, rs, 1'b1, 5'd0, 1'b0, 3'd0, 1'b0, e);
    endfunction

    function automatic step_t idle(logic [4:0] e);
        return mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0, 1'b0, e);
    endfunction

    function automatic step_t brk(logic [4:0] e);
        return mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0, 1'b1, e);
    endfunction

    function automatic logic [4:0] outs();
        return {pc_en_o, if_en_o, inhibit_ctrl_o, flush_o, stall_o};
    endfunction

    task automatic apply(input step_t s);
        id_valid_i     = s.v;
        id_rs1_i       = s.rs1;
        id_rs1_used_i  = s.u1;
        id_rs2_i       = s.rs2;
        id_rs2_used_i  = s.u2;
        id_rd_i        = s.rd;
        id_rd_wr_i     = s.wr;
        id_lat_i       = s.lat;
        branch_taken_i = s.br;
        exp_q.push_back(s.exp);
        if (s.exp[0]) exp_stalls++;
        if (s.br) exp_branches++;
    endtask

    task automatic test_reset();
        logic [4:0] e;
        rst_n_i = 1'b0;
        apply(mk(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 3'd4, 1'b1, RUN));
        #2;
        e = exp_q.pop_front(); n_checks++;
        if (outs() !== e) begin n_fail++; $display("FAIL reset_hold: got %b expected %b", outs(), e); end
        @(negedge clk_i);
        rst_n_i = 1'b1;
        apply(prod(5'd5, 3'd4, RUN));
        #2;
        e = exp_q.pop_front(); n_checks++;
        if (outs() !== e) begin n_fail++; $display("FAIL reset_prod: got %b expected %b", outs(), e); end
        @(negedge clk_i);
        apply(cons1(5'd5, STL));
        #2;
        e = exp_q.pop_front(); n_checks++;
        if (outs() !== e) begin n_fail++; $display("FAIL reset_pre_stall: got %b expected %b", outs(), e); end
        #1 rst_n_i = 1'b0;
        branch_taken_i = 1'b1;
        exp_q.push_back(RUN);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (outs() !== e) begin n_fail++; $display("FAIL reset_mid_stall: got %b expected %b", outs(), e); end
        @(negedge clk_i);
        rst_n_i = 1'b1;
        apply(cons1(5'd5, RUN));
        #2;
        e = exp_q.pop_front(); n_checks++;
        if (outs() !== e) begin n_fail++; $display("FAIL reset_cnt_cleared: got %b expected %b", outs(), e); end
        @(negedge clk_i);
        apply(brk(BRK));
        #2;
        e = exp_q.pop_front(); n_checks++;
        if (outs() !== e) begin n_fail++; $display("FAIL reset_pre_flush: got %b expected %b", outs(), e); end
        @(negedge clk_i);
        apply(idle(FLS));
        #2;
        e = exp_q.pop_front(); n_checks++;
        if (outs() !== e) begin n_fail++; $display("FAIL reset_flush_tail: got %b expected %b", outs(), e); end
        #1 rst_n_i = 1'b0;
        exp_q.push_back(RUN);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (outs() !== e) begin n_fail++; $display("FAIL reset_mid_flush: got %b expected %b", outs(), e); end
        @(negedge clk_i);
        rst_n_i = 1'b1;
        apply(idle(RUN));
        #2;
        e = exp_q.pop_front(); n_checks++;
        if (outs() !== e) begin n_fail++; $display("FAIL reset_fcnt_cleared: got %b expected %b", outs(), e); end
        @(negedge clk_i);
        exp_stalls   = 0;
        exp_branches = 0;
    endtask

    task automatic test_load_use();
        logic [4:0] e;
        step_t s;
        int i = 0;
        steps.push_back(prod(5'd5, 3'd1, RUN));
        steps.push_back(cons1(5'd5, STL));
        steps.push_back(cons1(5'd5, RUN));
        steps.push_back(prod(5'd6, 3'd0, RUN));
        steps.push_back(cons1(5'd6, RUN));
        while (steps.size() != 0) begin
            s = steps.pop_front();
            apply(s);
            #2;
            e = exp_q.pop_front(); n_checks++;
            if (outs() !== e) begin n_fail++; $display("FAIL load_use step %0d: got %b expected %b", i, outs(), e); end
            i++;
            @(negedge clk_i);
        end
    endtask

    task automatic test_multi_cycle();
        logic [4:0] e;
        step_t s;
        int i = 0;
        steps.push_back(prod(5'd7, 3'd4, RUN));
        for (int k = 0; k < 4; k++) steps.push_back(cons2(5'd7, STL));
        steps.push_back(cons2(5'd7, RUN));
        steps.push_back(prod(5'd7, 3'd4, RUN));
        steps.push_back(mk(1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0, 1'b0, RUN));
        steps.push_back(mk(1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 3'd0, 1'b0, RUN));
        for (int k = 0; k < 2; k++) steps.push_back(idle(RUN));
        steps.push_back(prod(5'd0, 3'd4, RUN));
        steps.push_back(cons1(5'd0, RUN));
        steps.push_back(cons2(5'd0, RUN));
        while (steps.size() != 0) begin
            s = steps.pop_front();
            apply(s);
            #2;
            e = exp_q.pop_front(); n_checks++;
            if (outs() !== e) begin n_fail++; $display("FAIL multi_cycle step %0d: got %b expected %b", i, outs(), e); end
            i++;
            @(negedge clk_i);
        end
    endtask

    task automatic test_overwrite();
        logic [4:0] e;
        step_t s;
        int i = 0;
        steps.push_back(prod(5'd3, 3'd4, RUN));
        steps.push_back(prod(5'd3, 3'd1, RUN));
        steps.push_back(cons1(5'd3, STL));
        steps.push_back(cons1(5'd3, RUN));
        while (steps.size() != 0) begin
            s = steps.pop_front();
            apply(s);
            #2;
            e = exp_q.pop_front(); n_checks++;
            if (outs() !== e) begin n_fail++; $display("FAIL overwrite step %0d: got %b expected %b", i, outs(), e); end
            i++;
            @(negedge clk_i);
        end
    endtask

    task automatic test_flush();
        logic [4:0] e;
        step_t s;
        int i = 0;
        // plain pulse; producer during flush is dropped
        steps.push_back(brk(BRK));
        steps.push_back(prod(5'd9, 3'd2, FLS));
        steps.push_back(prod(5'd9, 3'd2, FLS));
        steps.push_back(cons1(5'd9, RUN));
        // producer in the branch cycle is dropped
        steps.push_back(mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 3'd3, 1'b1, BRK));
        steps.push_back(idle(FLS));
        steps.push_back(idle(FLS));
        steps.push_back(cons1(5'd10, RUN));
        // in-flight entry survives a flush
        steps.push_back(prod(5'd12, 3'd4, RUN));
        steps.push_back(brk(BRK));
        steps.push_back(idle(FLS));
        steps.push_back(idle(FLS));
        steps.push_back(cons1(5'd12, STL));
        steps.push_back(cons1(5'd12, RUN));
        // branch during an active flush reloads it
        steps.push_back(brk(BRK));
        steps.push_back(idle(FLS));
        steps.push_back(brk(BRK));
        steps.push_back(idle(FLS));
        steps.push_back(idle(FLS));
        steps.push_back(idle(RUN));
        while (steps.size() != 0) begin
            s = steps.pop_front();
            apply(s);
            #2;
            e = exp_q.pop_front(); n_checks++;
            if (outs() !== e) begin n_fail++; $display("FAIL flush step %0d: got %b expected %b", i, outs(), e); end
            i++;
            @(negedge clk_i);
        end
    endtask

    task automatic test_branch_in_stall();
        logic [4:0] e;
        step_t s;
        int i = 0;
        steps.push_back(prod(5'd11, 3'd4, RUN));
        steps.push_back(mk(1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 5'd14, 1'b1, 3'd4, 1'b0, STL));
        steps.push_back(mk(1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 5'd14, 1'b1, 3'd4, 1'b1, BRK));
        steps.push_back(idle(FLS));
        steps.push_back(idle(FLS));
        steps.push_back(cons1(5'd14, RUN));
        steps.push_back(cons2(5'd14, RUN));
        while (steps.size() != 0) begin
            s = steps.pop_front();
            apply(s);
            #2;
            e = exp_q.pop_front(); n_checks++;
            if (outs() !== e) begin n_fail++; $display("FAIL branch_in_stall step %0d: got %b expected %b", i, outs(), e); end
            i++;
            @(negedge clk_i);
        end
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf();
        logic [4:0] e;
        step_t s;
        int i = 0;
        n_checks++;
        if (stall_cnt_o !== 32'(exp_stalls)) begin
            n_fail++; $display("FAIL perf_stall_running: got %0d expected %0d", stall_cnt_o, exp_stalls);
        end
        n_checks++;
        if (flush_cnt_o !== 32'(exp_branches)) begin
            n_fail++; $display("FAIL perf_flush_running: got %0d expected %0d", flush_cnt_o, exp_branches);
        end
        rst_n_i = 1'b0;
        #1 rst_n_i = 1'b1;
        steps.push_back(prod(5'd13, 3'd3, RUN));
        for (int k = 0; k < 3; k++) steps.push_back(cons1(5'd13, STL));
        steps.push_back(cons1(5'd13, RUN));
        steps.push_back(brk(BRK));
        steps.push_back(idle(FLS));
        steps.push_back(brk(BRK));
        steps.push_back(idle(FLS));
        steps.push_back(idle(FLS));
        while (steps.size() != 0) begin
            s = steps.pop_front();
            apply(s);
            #2;
            e = exp_q.pop_front(); n_checks++;
            if (outs() !== e) begin n_fail++; $display("FAIL perf step %0d: got %b expected %b", i, outs(), e); end
            i++;
            @(negedge clk_i);
        end
        n_checks++;
        if (stall_cnt_o !== 32'd3) begin n_fail++; $display("FAIL perf_stall_cnt: got %0d expected 3", stall_cnt_o); end
        n_checks++;
        if (flush_cnt_o !== 32'd2) begin n_fail++; $display("FAIL perf_flush_cnt: got %0d expected 2", flush_cnt_o); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load_use();
        test_multi_cycle();
        test_overwrite();
        test_flush();
        test_branch_in_stall();
`ifdef HAZARD_PERF_CNT_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
